out_serializer: RTL and testbench

Parametrised output serializer for the DCT datapath. It captures a full coefficient vector of ARRSIZE floating-point words (sign + E exponent + M mantissa) in one handshake, then streams it out LANES words per beat under valid/ready flow control, with first/last beat markers and a completion pulse. It sits between the DCT compute array and the downstream consumer (memory writer or serial link), and supports multi-lane output and backpressure.

---
 rtl/out_serializer_pkg.sv | 30 +++
 rtl/out_serializer_if.sv | 39 +++
 rtl/out_beat_mux.sv | 40 ++++
 rtl/out_serializer.sv | 171 +++++++++++++++++
 tb/tb_out_serializer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/out_serializer_pkg.sv
// -----------------------------------------------------------------------------
// out_serializer_pkg
// Shared types and helpers for the output serializer:
//   state_e     - drain FSM states (IDLE, DRAIN)
//   w()         - floating-point word width: sign + exponent + mantissa
//   beats()     - number of output beats per vector
//   beat_width()- width of the beat counter, never narrower than one bit
// -----------------------------------------------------------------------------
package out_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    function automatic int w(input int m, input int e);
        return m + e + 1;
    endfunction

    // Guarded so an illegal LANES still elaborates far enough to hit the
    // explicit parameter check in the top.
    function automatic int beats(input int arrsize, input int lanes);
        return (lanes > 0) ? arrsize / lanes : 1;
    endfunction

    function automatic int beat_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/out_serializer_if.sv
// -----------------------------------------------------------------------------
// out_serializer_if
// Handshake bundle of the output serializer.
//   in_data/in_valid/in_ready    - vector input, word i at [i*W +: W]
//   out_data/out_valid/out_ready - beat output, lane j at [j*W +: W]
//   out_first/out_last           - beat 0 / beat BEATS-1 markers
//   done                         - one-cycle pulse after the last beat is taken
//   busy                         - a vector is held or draining
// Modports: slave = serializer side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface out_serializer_if #(
    parameter int M       = 23,
    parameter int E       = 8,
    parameter int ARRSIZE = 16,
    parameter int LANES   = 1
) ();
    localparam int W = out_serializer_pkg::w(M, E);

    logic [ARRSIZE*W-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_first;
    logic                 out_last;
    logic                 done;
    logic                 busy;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_first, out_last, done, busy
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_first, out_last, done, busy
    );
endinterface

// File: rtl/out_beat_mux.sv
// -----------------------------------------------------------------------------
// out_beat_mux
// Combinational selection of one beat (LANES words) out of a vector bank.
//   bank  - ARRSIZE*W vector
//   beat  - beat index k, selects words k*LANES .. k*LANES+LANES-1
//   valid - when low the output is forced to zero
//   data  - LANES*W beat
// -----------------------------------------------------------------------------
module out_beat_mux
    import out_serializer_pkg::*;
#(
    parameter int W       = 32,
    parameter int LANES   = 1,
    parameter int ARRSIZE = 16,
    localparam int BEATS  = beats(ARRSIZE, LANES),
    localparam int BW     = beat_width(BEATS)
) (
    input  logic [ARRSIZE*W-1:0] bank,
    input  logic [BW-1:0]        beat,
    input  logic                 valid,
    output logic [LANES*W-1:0]   data
);

    // Constant slice positions per beat keep every part-select in range,
    // including non-power-of-two beat counts.
    always_comb begin
        // NOTE: assigning a default before any condition keeps this block
        // purely combinational; a path that leaves data unassigned would
        // infer a latch.
        data = '0;
        if (valid) begin
            for (int k = 0; k < BEATS; k++) begin
                if (beat == BW'(k)) begin
                    data = bank[k*LANES*W +: LANES*W];
                end
            end
        end
    end

endmodule

// File: rtl/out_serializer.sv
// -----------------------------------------------------------------------------
// out_serializer
// Captures a vector of ARRSIZE floating-point words in one handshake and
// streams it out LANES words per beat with valid/ready flow control.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - out_serializer_if.slave (vector in, beats out, done, busy)
// Build option OUT_SERIALIZER_DBUF_EN: adds a pending bank so the next
// vector can be accepted during a drain and follows with no idle cycle.
// Without it a single bank is used and one idle cycle separates vectors.
// All outputs come from flops or are decoded from flopped state only.
// -----------------------------------------------------------------------------
module out_serializer
    import out_serializer_pkg::*;
#(
    parameter int M       = 23,
    parameter int E       = 8,
    parameter int ARRSIZE = 16,
    parameter int LANES   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    out_serializer_if.slave  bus
);

    localparam int W     = w(M, E);
    localparam int VW    = ARRSIZE * W;
    localparam int BEATS = beats(ARRSIZE, LANES);
    localparam int BW    = beat_width(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    generate
        if (LANES < 1) begin : g_bad_lanes
            $error("out_serializer: LANES must be at least 1");
        end else if (ARRSIZE % LANES != 0) begin : g_bad_split
            $error("out_serializer: LANES must divide ARRSIZE");
        end
    endgenerate

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [VW-1:0]   active_q, active_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef OUT_SERIALIZER_DBUF_EN
    logic [VW-1:0]   pending_q, pending_d;
    logic            pending_full_q, pending_full_d;
`endif

    logic accept;
    logic consume;
    logic retire;

    assign accept  = bus.in_valid && in_ready_q;
    assign consume = out_valid_q && bus.out_ready;
    assign retire  = consume && (beat_q == LAST_BEAT);

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        active_d = active_q;
        done_d   = 1'b0;
`ifdef OUT_SERIALIZER_DBUF_EN
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    active_d = bus.in_data;
                    beat_d   = '0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (consume && !retire) begin
                    beat_d = beat_q + BW'(1);
                end
`ifdef OUT_SERIALIZER_DBUF_EN
                if (accept && !retire) begin
                    pending_d      = bus.in_data;
                    pending_full_d = 1'b1;
                end
                if (retire) begin
                    done_d = 1'b1;
                    beat_d = '0;
                    // Hand over straight to the next vector; one arriving in
                    // the retiring cycle bypasses the pending bank.
                    if (pending_full_q) begin
                        active_d       = pending_q;
                        pending_full_d = 1'b0;
                    end else if (accept) begin
                        active_d = bus.in_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
`else
                if (retire) begin
                    done_d  = 1'b1;
                    beat_d  = '0;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DRAIN);
`ifdef OUT_SERIALIZER_DBUF_EN
        in_ready_d  = !pending_full_d;
        busy_d      = (state_d == DRAIN) || pending_full_d;
`else
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d == DRAIN);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            // NOTE: the data banks are reset too, so a discarded vector can
            // never reappear on out_data after reset.
            active_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef OUT_SERIALIZER_DBUF_EN
            pending_q      <= '0;
            pending_full_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state_q     <= state_d;
            beat_q      <= beat_d;
            active_q    <= active_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef OUT_SERIALIZER_DBUF_EN
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
`endif
        end
    end

    out_beat_mux #(
        .W       (W),
        .LANES   (LANES),
        .ARRSIZE (ARRSIZE)
    ) u_beat_mux (
        .bank  (active_q),
        .beat  (beat_q),
        .valid (out_valid_q),
        .data  (bus.out_data)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_valid_q && (beat_q == '0);
    assign bus.out_last  = out_valid_q && (beat_q == LAST_BEAT);
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_out_serializer.sv
// -----------------------------------------------------------------------------
// tb_out_serializer
// Three serializer instances share clock and reset:
//   a: ARRSIZE=4,  LANES=1   (order, backpressure, back-to-back, reset)
//   b: ARRSIZE=4,  LANES=2   (two-lane beats)
//   c: ARRSIZE=16, LANES=16  (single beat)
// Expected beats are queued when a vector is offered and checked as the
// serializer hands them out. Build with OUT_SERIALIZER_DBUF_EN to cover the
// double-buffered variant.
// -----------------------------------------------------------------------------
module tb_out_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    out_serializer_if #(.M(23), .E(8), .ARRSIZE(4),  .LANES(1))  a_if ();
    out_serializer_if #(.M(23), .E(8), .ARRSIZE(4),  .LANES(2))  b_if ();
    out_serializer_if #(.M(23), .E(8), .ARRSIZE(16), .LANES(16)) c_if ();

    out_serializer #(.M(23), .E(8), .ARRSIZE(4), .LANES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if)
    );
    out_serializer #(.M(23), .E(8), .ARRSIZE(4), .LANES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if)
    );
    out_serializer #(.M(23), .E(8), .ARRSIZE(16), .LANES(16)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(c_if)
    );

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } exp_t;

    exp_t         q[3][$];
    logic         exp_done[3];
    logic         stall[3];
    logic [511:0] prev_d[3];
    logic         prev_f[3];
    logic         prev_l[3];
    int           last_cyc[3];
    int           gap[3];
    int           lanes_of[3] = '{1, 2, 16};
    int           arr_of[3]   = '{4, 4, 16};

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle observation of one instance, called at the falling edge.
    task automatic monitor(input int id, input logic v, input logic r,
                           input logic [511:0] d, input logic f, input logic l,
                           input logic dn);
        exp_t e;
        if (!rst_n) begin
            exp_done[id] = 1'b0;
            stall[id]    = 1'b0;
            return;
        end
        check($sformatf("done%0d", id), 512'(dn), 512'(exp_done[id]));
        if (!v) begin
            check($sformatf("idle_data%0d", id), d, '0);
            check($sformatf("idle_marks%0d", id), 512'(f | l), '0);
        end
        if (stall[id]) begin
            check($sformatf("hold_valid%0d", id), 512'(v), 512'(1));
            check($sformatf("hold_data%0d", id), d, prev_d[id]);
            check($sformatf("hold_marks%0d", id), 512'({f, l}), 512'({prev_f[id], prev_l[id]}));
        end
        stall[id]    = v && !r;
        prev_d[id]   = d;
        prev_f[id]   = f;
        prev_l[id]   = l;
        exp_done[id] = 1'b0;
        if (v && r) begin
            if (q[id].size() == 0) begin
                check($sformatf("unexpected_beat%0d", id), 512'(v && r), '0);
            end else begin
                e = q[id].pop_front();
                check($sformatf("beat_data%0d", id), d, e.data);
                check($sformatf("beat_first%0d", id), 512'(f), 512'(e.first));
                check($sformatf("beat_last%0d", id), 512'(l), 512'(e.last));
                if (e.first) gap[id] = cyc - last_cyc[id];
                if (e.last)  last_cyc[id] = cyc;
                exp_done[id] = e.last;
            end
        end
    endtask

    always @(negedge clk) monitor(0, a_if.out_valid, a_if.out_ready, 512'(a_if.out_data),
                                  a_if.out_first, a_if.out_last, a_if.done);
    always @(negedge clk) monitor(1, b_if.out_valid, b_if.out_ready, 512'(b_if.out_data),
                                  b_if.out_first, b_if.out_last, b_if.done);
    always @(negedge clk) monitor(2, c_if.out_valid, c_if.out_ready, 512'(c_if.out_data),
                                  c_if.out_first, c_if.out_last, c_if.done);

    task automatic set_in(input int id, input logic [511:0] vec, input logic v);
        case (id)
            0: begin a_if.in_data = vec[127:0]; a_if.in_valid = v; end
            1: begin b_if.in_data = vec[127:0]; b_if.in_valid = v; end
            default: begin c_if.in_data = vec; c_if.in_valid = v; end
        endcase
    endtask

    function automatic logic get_ready(input int id);
        case (id)
            0:       return a_if.in_ready;
            1:       return b_if.in_ready;
            default: return c_if.in_ready;
        endcase
    endfunction

    function automatic logic get_busy(input int id);
        case (id)
            0:       return a_if.busy;
            1:       return b_if.busy;
            default: return c_if.busy;
        endcase
    endfunction

    // Queue the expected beats, then hold in_valid until the handshake edge.
    // Returns 1 time unit after that edge.
    task automatic send(input int id, input logic [511:0] vec);
        int   nl = lanes_of[id];
        int   nb = arr_of[id] / lanes_of[id];
        logic ok = 1'b0;
        exp_t e;
        for (int k = 0; k < nb; k++) begin
            e.data = '0;
            for (int j = 0; j < nl; j++) e.data[j*32 +: 32] = vec[(k*nl + j)*32 +: 32];
            e.first = (k == 0);
            e.last  = (k == nb - 1);
            q[id].push_back(e);
        end
        set_in(id, vec, 1'b1);
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = get_ready(id);
            @(posedge clk);
        end
        #1;
        set_in(id, '0, 1'b0);
        check($sformatf("accept%0d", id), 512'(ok), 512'(1));
    endtask

    task automatic wait_idle(input int id);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (q[id].size() == 0 && !get_busy(id)) break;
        end
        check($sformatf("drained%0d", id), 512'(q[id].size()), '0);
        check($sformatf("busy_end%0d", id), 512'(get_busy(id)), '0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string pfx);
        check({pfx, "_valid"}, 512'(a_if.out_valid), '0);
        check({pfx, "_data"},  512'(a_if.out_data), '0);
        check({pfx, "_first"}, 512'(a_if.out_first), '0);
        check({pfx, "_last"},  512'(a_if.out_last), '0);
        check({pfx, "_done"},  512'(a_if.done), '0);
        check({pfx, "_busy"},  512'(a_if.busy), '0);
        check({pfx, "_ready"}, 512'(a_if.in_ready), 512'(1));
    endtask

    logic [127:0] va;
    logic [127:0] vb;
    logic [127:0] vc;
    logic [511:0] v16;

    initial begin
        va = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        vb = {32'hC1200000, 32'h00000001, 32'h7F7FFFFF, 32'h80000000};
        vc = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        for (int i = 0; i < 16; i++) v16[i*32 +: 32] = 32'hA5000000 + 32'(i * 3);
        for (int i = 0; i < 3; i++) begin
            exp_done[i] = 1'b0;
            stall[i]    = 1'b0;
            last_cyc[i] = 0;
            gap[i]      = 0;
            set_in(i, '0, 1'b0);
        end
        a_if.out_ready = 1'b1;
        b_if.out_ready = 1'b1;
        c_if.out_ready = 1'b1;

        #23;
        check_reset_a("rst0");
        check("rst0_c_ready", 512'(c_if.in_ready), 512'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic drain, one lane: beat 0 visible right after the handshake.
        send(0, 512'(va));
        check("lat_valid", 512'(a_if.out_valid), 512'(1));
        check("lat_first", 512'(a_if.out_first), 512'(1));
        check("lat_data",  512'(a_if.out_data), 512'(32'h3F800000));
        wait_idle(0);

        // Two lanes.
        send(1, 512'(va));
        check("b_beat0", 512'(b_if.out_data), 512'(64'h40000000_3F800000));
        wait_idle(1);

        // Backpressure 1,0,0,1: beat 1 held for two cycles.
        send(0, 512'(vb));
        @(posedge clk);
        #1;
        a_if.out_ready = 1'b0;
        check("bp_beat1", 512'(a_if.out_data), 512'(32'h7F7FFFFF));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("bp_still_beat1", 512'(a_if.out_data), 512'(32'h7F7FFFFF));
        a_if.out_ready = 1'b1;
        wait_idle(0);

        // Back-to-back vectors with continuous out_ready.
        send(0, 512'(va));
        send(0, 512'(vb));
        check("b2b_in_ready", 512'(a_if.in_ready), '0);
        check("b2b_busy", 512'(a_if.busy), 512'(1));
        wait_idle(0);
`ifdef OUT_SERIALIZER_DBUF_EN
        check("b2b_gap", 512'(gap[0]), 512'(1));
`else
        check("b2b_gap", 512'(gap[0]), 512'(2));
`endif

        // Reset in the middle of beat 2: vector dropped, no done pulse.
        send(0, 512'(vc));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_beat2", 512'(a_if.out_data), 512'(32'h22222222));
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_a("rst_mid");
        q[0].delete();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 512'(va));
        check("post_rst_first", 512'(a_if.out_first), 512'(1));
        wait_idle(0);

        // Single beat: first and last together.
        send(2, v16);
        check("c_first", 512'(c_if.out_first), 512'(1));
        check("c_last",  512'(c_if.out_last), 512'(1));
        wait_idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
